// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter: request payload and
// slot-source encoding.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_ALU
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the ALU/load producer handshakes and regfile write-port outputs
// around the writeback arbiter.
interface wb_arbiter_if #(
  parameter int ALU_DEPTH = 2
);
  import wb_pkg::*;

  localparam int CNT_W = $clog2(ALU_DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [AW-1:0]     alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [AW-1:0]     mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              we;
  logic [AW-1:0]     wa;
  logic [XLEN-1:0]   wd;
  logic [2**AW-1:0]  pend_mask;
  logic [CNT_W-1:0]  alu_cnt;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, we, wa, wd, pend_mask, alu_cnt
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, we, wa, wd, pend_mask, alu_cnt
  );

endinterface

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO of writeback requests; also exposes per-slot
// destination registers and valid bits so the owner can build a hazard mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  wb_req_t          i_din,
  input  logic             i_pop,
  output wb_req_t          o_head,
  output logic [CNT_W-1:0] o_cnt,
  output logic [AW-1:0]    o_rd [DEPTH],
  output logic [DEPTH-1:0] o_valid
);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (i_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PTR_W-1:0] w_off;
    w_off   = '0;
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PTR_W'(i) - r_rptr;
      o_valid[i] = ({1'b0, w_off} < r_cnt);
      o_rd[i]    = r_mem[i].rd;
    end
  end

  assign o_head = r_mem[r_rptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: merges load results (priority) and buffered ALU results
// into a single registered regfile write per cycle, with anti-starvation.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int ALU_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(ALU_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]        r_starve;
  logic                 r_we;
  logic [AW-1:0]        r_wa;
  logic [XLEN-1:0]      r_wd;

  wb_req_t              w_head;
  wb_req_t              w_din;
  logic [CNT_W-1:0]     w_cnt;
  logic [AW-1:0]        w_rd [ALU_DEPTH];
  logic [ALU_DEPTH-1:0] w_valid;
  logic                 w_alu_ready;
  logic                 w_mem_ready;
  logic                 w_fifo_ne;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_mem_win;
  wb_src_e              w_src;
  logic [2**AW-1:0]     w_pend;

  assign w_fifo_ne   = (w_cnt != '0);
  assign w_alu_ready = (w_cnt != CNT_W'(ALU_DEPTH));
  assign w_mem_ready = !((r_starve == SW'(STARVE_MAX)) && w_fifo_ne);

  // x0 destinations complete their handshake but never occupy a slot.
  assign w_push    = bus.alu_valid && w_alu_ready && (bus.alu_rd != '0);
  assign w_mem_win = bus.mem_valid && w_mem_ready && (bus.mem_rd != '0);
  assign w_din     = '{rd: bus.alu_rd, data: bus.alu_data};
  assign w_pop     = (w_src == SRC_ALU);

  always_comb begin
    w_src = SRC_NONE;
    if (w_mem_win) begin
      w_src = SRC_MEM;
    end else if (w_fifo_ne) begin
      w_src = SRC_ALU;
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < ALU_DEPTH; i++) begin
      if (w_valid[i]) begin
        w_pend[w_rd[i]] = 1'b1;
      end
    end
  end

  wb_fifo #(
    .DEPTH (ALU_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_cnt   (w_cnt),
    .o_rd    (w_rd),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_wa     <= '0;
      r_wd     <= '0;
      r_starve <= '0;
    end else begin
      case (w_src)
        SRC_MEM: begin
          r_we <= 1'b1;
          r_wa <= bus.mem_rd;
          r_wd <= bus.mem_data;
        end
        SRC_ALU: begin
          r_we <= 1'b1;
          r_wa <= w_head.rd;
          r_wd <= w_head.data;
        end
        default: r_we <= 1'b0;
      endcase
      // Count mem wins only while ALU work waits; saturate at the limit.
      if (!w_fifo_ne || (w_src == SRC_ALU)) begin
        r_starve <= '0;
      end else if ((w_src == SRC_MEM) && (r_starve != SW'(STARVE_MAX))) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  assign bus.alu_ready = w_alu_ready;
  assign bus.mem_ready = w_mem_ready;
  assign bus.we        = r_we;
  assign bus.wa        = r_wa;
  assign bus.wd        = r_wd;
  assign bus.pend_mask = w_pend;
  assign bus.alu_cnt   = w_cnt;

endmodule
